// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive sequencer.
// The frame length counts the data bits plus the stop bit.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        ACCEPT     = 3'd2,
        STOP_CHECK = 3'd3,
        FRAME_EVAL = 3'd4,
        LOAD       = 3'd5
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_FRAME_BITS   = DEFAULT_DATA_BITS + 1;

    function automatic int frame_len(input int data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Counter that runs 1..rollover_val and wraps back to 1, with a synchronous clear.
// rollover_flag is a decode of the registered count, high while count == rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= NUM_CNT_BITS'(1);
            end else begin
                count_out <= count_out + NUM_CNT_BITS'(1);
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/rx_sequencer.sv
// UART receive sequencer: control FSM plus bit timing built from two flex counters.
// Times the mid-bit sample of each data bit and the stop bit, then gates the buffer load.
module rx_sequencer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int CNT_BITS     = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic framing_error,
    output logic shift_strobe,
    output logic packet_done,
    output logic sbc_clear,
    output logic sbc_enable,
    output logic load_buffer,
    output logic rx_busy
);

    localparam logic [CNT_BITS-1:0] PERIOD_MAX = CNT_BITS'(CLKS_PER_BIT);
    localparam logic [CNT_BITS-1:0] HALF_BIT   = CNT_BITS'(CLKS_PER_BIT / 2);
    localparam logic [CNT_BITS-1:0] FRAME_MAX  = CNT_BITS'(frame_len(DATA_BITS));

    rx_state_t state;

    logic [CNT_BITS-1:0] pc;
    logic [CNT_BITS-1:0] bc;
    logic                pc_wrap;
    logic                bc_wrap;
    logic                pc_clear;
    logic                pc_enable;
    logic                bc_clear;
    logic                bc_enable;

    // The period counter already steps out of CLEAR so the first ACCEPT cycle sees pc=1;
    // both counters sit at zero through IDLE and CLEAR, so CLEAR starts them from clean.
    assign pc_clear  = (state == IDLE);
    assign pc_enable = (state == CLEAR) || (state == ACCEPT);
    assign bc_clear  = (state == IDLE) || (state == CLEAR);
    assign bc_enable = (state == ACCEPT) && pc_wrap;

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_period_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (pc_clear),
        .count_enable  (pc_enable),
        .rollover_val  (PERIOD_MAX),
        .count_out     (pc),
        .rollover_flag (pc_wrap)
    );

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bc_clear),
        .count_enable  (bc_enable),
        .rollover_val  (FRAME_MAX),
        .count_out     (bc),
        .rollover_flag (bc_wrap)
    );

    // bc == 0 is the start bit and never strobes; bc_wrap marks the stop bit.
    assign shift_strobe = (state == ACCEPT) && (pc == HALF_BIT) &&
                          (bc != '0) && (bc <= FRAME_MAX);
    assign packet_done  = shift_strobe && bc_wrap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            sbc_clear   <= 1'b0;
            sbc_enable  <= 1'b0;
            load_buffer <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            sbc_clear   <= 1'b0;
            sbc_enable  <= 1'b0;
            load_buffer <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_bit_detected) begin
                        state     <= CLEAR;
                        sbc_clear <= 1'b1;
                        rx_busy   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= ACCEPT;
                end
                ACCEPT: begin
                    if (packet_done) begin
                        state      <= STOP_CHECK;
                        sbc_enable <= 1'b1;
                    end
                end
                STOP_CHECK: begin
                    state <= FRAME_EVAL;
                end
                FRAME_EVAL: begin
                    if (framing_error) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state       <= LOAD;
                        load_buffer <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer: a frame-level model schedules the cycle of every
// expected output pulse, and a negedge monitor compares each output every cycle.
module tb_rx_sequencer;

    localparam int C = 10;
    localparam int D = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic start_bit_detected = 1'b0;
    logic framing_error = 1'b0;
    logic shift_strobe;
    logic packet_done;
    logic sbc_clear;
    logic sbc_enable;
    logic load_buffer;
    logic rx_busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int q_strobe[$];
    int q_done[$];
    int q_clear[$];
    int q_enable[$];
    int q_load[$];
    int busy_start = 0;
    int busy_end = 0;

    rx_sequencer #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (D),
        .CNT_BITS     (4)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .framing_error      (framing_error),
        .shift_strobe       (shift_strobe),
        .packet_done        (packet_done),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .load_buffer        (load_buffer),
        .rx_busy            (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: a start in an idle cycle s schedules every pulse of that frame.
    task automatic applyStimulus(input logic fe);
        int last;
        if (n_rst && cyc >= busy_end) begin
            framing_error = fe;
            last = cyc + 1 + (D + 1) * C + C / 2;
            q_clear.push_back(cyc + 1);
            for (int j = 1; j <= D + 1; j++) q_strobe.push_back(cyc + 1 + j * C + C / 2);
            q_done.push_back(last);
            q_enable.push_back(last + 1);
            if (!fe) q_load.push_back(last + 3);
            busy_start = cyc + 1;
            busy_end   = fe ? last + 3 : last + 4;
        end
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assertReset(input int n);
        n_rst = 1'b0;
        q_strobe.delete();
        q_done.delete();
        q_clear.delete();
        q_enable.delete();
        q_load.delete();
        busy_end = cyc;
        for (int i = 0; i < n; i++) begin
            start_bit_detected = 1'b1;
            tick();
        end
        start_bit_detected = 1'b0;
        n_rst = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin : monitor
        logic e_st, e_pd, e_cl, e_en, e_ld, e_busy;
        e_st = (q_strobe.size() > 0 && q_strobe[0] == cyc);
        if (e_st) void'(q_strobe.pop_front());
        e_pd = (q_done.size() > 0 && q_done[0] == cyc);
        if (e_pd) void'(q_done.pop_front());
        e_cl = (q_clear.size() > 0 && q_clear[0] == cyc);
        if (e_cl) void'(q_clear.pop_front());
        e_en = (q_enable.size() > 0 && q_enable[0] == cyc);
        if (e_en) void'(q_enable.pop_front());
        e_ld = (q_load.size() > 0 && q_load[0] == cyc);
        if (e_ld) void'(q_load.pop_front());
        e_busy = n_rst && (cyc >= busy_start) && (cyc < busy_end);
        checkOutput("shift_strobe", shift_strobe, e_st);
        checkOutput("packet_done", packet_done, e_pd);
        checkOutput("sbc_clear", sbc_clear, e_cl);
        checkOutput("sbc_enable", sbc_enable, e_en);
        checkOutput("load_buffer", load_buffer, e_ld);
        checkOutput("rx_busy", rx_busy, e_busy);
    end

    initial begin
        int s;
        #1 n_rst = 1'b0;
        tick();
        assertReset(2);
        idleCycles(3);

        // Good frame, then a frame with a framing error.
        applyStimulus(1'b0);
        idleCycles(105);
        applyStimulus(1'b1);
        idleCycles(105);

        // Extra start pulses mid-frame must not disturb timing.
        s = cyc;
        applyStimulus(1'b0);
        while (cyc < s + 20) tick();
        applyStimulus(1'b1);
        while (cyc < s + 50) tick();
        applyStimulus(1'b1);
        idleCycles(60);

        // Back-to-back: second start on the first idle cycle.
        s = cyc;
        applyStimulus(1'b0);
        while (cyc < s + 100) tick();
        applyStimulus(1'b0);
        idleCycles(105);

        // Reset in the middle of a frame, then a clean frame.
        s = cyc;
        applyStimulus(1'b0);
        while (cyc < s + 40) tick();
        assertReset(2);
        idleCycles(2);
        applyStimulus(1'b0);
        idleCycles(105);

        // Randomized frames with stray start pulses.
        for (int f = 0; f < 6; f++) begin
            applyStimulus(1'($urandom_range(0, 1)));
            for (int k = 0; k < 100 + int'($urandom_range(0, 6)); k++) begin
                if ($urandom_range(0, 25) == 0) applyStimulus(1'($urandom_range(0, 1)));
                else tick();
            end
        end
        idleCycles(120);

        checkOutput("scoreboard_drained",
                    (q_strobe.size() + q_done.size() + q_clear.size() +
                     q_enable.size() + q_load.size()) == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
